cmos_capture_rgb: RTL and testbench
===================================

Name: cmos_capture_rgb

Overview:
- Camera-side capture front end for an 8-bit parallel CMOS sensor (OV-style) delivering RGB565 as two bytes per pixel.
- Runs entirely in the sensor pixel-clock domain.
- Discards the first FRAME_WAIT frames after reset so sensor register settings can settle.
- Pairs bytes into pixels, expands RGB565 to RGB888 and emits gated frame/line/data-valid strobes for the downstream frame buffer writer.

Parameters:
- FRAME_WAIT, 10, number of complete frames dropped after reset before output is enabled (1..255).

Ports:
- cmos_pclk  input  1  sensor pixel clock; the only clock.
- sys_rst_n  input  1  reset, asynchronous, active-low.
- cmos_vsync  input  1  frame active, high for the whole frame.
- cmos_herf  input  1  line active; high while valid bytes are present.
- cmos_data  input  8  sensor byte.
- cmos_pclk_ce  output  1  one-cycle pixel strobe per completed byte pair, not gated by frame enable.
- cmos_frame_vsync  output  1  gated, delayed vsync.
- cmos_frame_herf  output  1  gated, delayed href.
- cmos_frame_valid  output  1  one-cycle strobe: cmos_frame_data holds a new pixel.
- cmos_frame_data  output  24  RGB888 pixel {R[7:0],G[7:0],B[7:0]}.

Behaviour:
- Clock and reset: one clock (cmos_pclk). Reset sys_rst_n is asynchronous, active-low. Reset clears all registers, the frame counter and the output enable. All outputs reset to 0.
- Input stage: vsync, href and data are registered twice (d1, d2). vsync_rise = d1 & ~d2.
- Frame skip:
  - An 8-bit frame_cnt increments on each vsync_rise while frame_cnt < FRAME_WAIT, then saturates.
  - out_en is set on a vsync_rise seen while frame_cnt == FRAME_WAIT.
  - Frames 1..FRAME_WAIT are therefore dropped and frame FRAME_WAIT+1 is the first output, always whole.
  - out_en stays set until reset.
- Byte pairing:
  - byte_flag toggles on every cycle where registered href (d1) is high.
  - byte_flag is forced to 0 whenever d1 href is low, so each line starts on a first byte.
  - First byte = high byte {R5,G6[5:3]}; second byte = low byte {G6[2:0],B5}.
  - On the second byte, the 16-bit word is formed and pix_stb pulses.
  - An odd trailing byte at line end is discarded; no strobe is produced for it.
- Expansion rules:
  - R8 = {R5,R5[4:2]}
  - G8 = {G6,G6[5:4]}
  - B8 = {B5,B5[4:2]}
- Latency:
  - If the second byte is on cmos_data at clock edge N, cmos_pclk_ce and (if enabled) cmos_frame_valid/data are high/valid after edge N+2, for exactly one cycle.
  - cmos_frame_data holds its value until the next pixel.
- Output gating and alignment:
  - cmos_frame_vsync and cmos_frame_herf equal the input vsync/href delayed by 3 edges, AND out_en, so they are aligned with data.
  - cmos_frame_valid = pix_stb & out_en.
  - cmos_pclk_ce = pix_stb, also during skipped frames.
- Line rate: one 1280-byte line yields 640 valid strobes, spaced every 2 cycles.
- Abnormal inputs:
  - An href pulse outside vsync is still paired and counted as pixels; no frame check is performed.
  - A vsync glitch counts as a frame.
- Reset mid-frame: outputs drop to 0 immediately; after release, frame skipping restarts from 0.

Test Plan:
1. Reset release, then 15 frames of 720 lines × 1280 bytes with FRAME_WAIT=10 → cmos_frame_vsync/valid stay 0 for frames 1–10. Frames 11–15 each give exactly 460800 valid strobes and 720 herf pulses of 1280 cycles.
2. Byte pair 0xF8,0x00 (pure red) → data 0xFF0000. Pair 0x07,0xE0 → 0x00FF00. Pair 0x00,0x1F → 0x0000FF. Pair 0x00,0x00 → 0x000000. Pair 0xFF,0xFF → 0xFFFFFF. Pair 0x84,0x10 → 0x848284.
3. Single pixel with second byte at edge N → cmos_frame_valid high after edge N+2 for one cycle. cmos_frame_herf rises 3 edges after the input href.
4. Line of 5 bytes (odd) → 2 valid strobes. Next line's first byte is treated as a high byte, and its pixel is correct.
5. During skipped frame 3, cmos_pclk_ce pulses 640 per line while cmos_frame_valid stays 0.
6. Assert sys_rst_n low mid-line in an output frame → all outputs 0 without waiting for a clock edge. After release, 10 more frames are skipped before output resumes.

Source files
------------

// File: rtl/cmos_capture_rgb.sv
// Capture an 8-bit RGB565 CMOS byte stream, pair bytes into pixels, and expand them to RGB888.
// Frame and line strobes are gated until FRAME_WAIT frames have passed. Pixel output comes 2 edges after the second byte.
module cmos_capture_rgb #(
  parameter int unsigned FRAME_WAIT = 10
) (
  input  logic        cmos_pclk,
  input  logic        sys_rst_n,
  input  logic        cmos_vsync,
  input  logic        cmos_herf,
  input  logic [7:0]  cmos_data,
  output logic        cmos_pclk_ce,
  output logic        cmos_frame_vsync,
  output logic        cmos_frame_herf,
  output logic        cmos_frame_valid,
  output logic [23:0] cmos_frame_data
);

  localparam logic [7:0] WAIT8 = 8'(FRAME_WAIT);

  logic        vsync_d1_q, vsync_d2_q;
  logic        href_d1_q, href_d2_q;
  logic [7:0]  data_d1_q;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        out_en_q, out_en_d;
  logic        byte_flag_q, byte_flag_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic [15:0] word_q, word_d;
  logic        pix_stb_q, pix_stb_d;
  logic        vsync_rise;
  logic [23:0] rgb888;

  assign vsync_rise = vsync_d1_q & ~vsync_d2_q;

  // Bit replication keeps full-scale 5/6-bit values mapping to 0xFF.
  assign rgb888 = {word_q[15:11], word_q[15:13],
                   word_q[10:5],  word_q[10:9],
                   word_q[4:0],   word_q[4:2]};

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    out_en_d    = out_en_q;
    if (vsync_rise) begin
      if (frame_cnt_q < WAIT8) frame_cnt_d = frame_cnt_q + 8'd1;
      if (frame_cnt_q == WAIT8) out_en_d = 1'b1;
    end

    // A low href clears the phase so every line starts on a high byte.
    byte_flag_d = 1'b0;
    hi_byte_d   = hi_byte_q;
    word_d      = word_q;
    pix_stb_d   = 1'b0;
    if (href_d1_q) begin
      byte_flag_d = ~byte_flag_q;
      if (byte_flag_q) begin
        word_d    = {hi_byte_q, data_d1_q};
        pix_stb_d = 1'b1;
      end else begin
        hi_byte_d = data_d1_q;
      end
    end
  end

  always_ff @(posedge cmos_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vsync_d1_q       <= 1'b0;
      vsync_d2_q       <= 1'b0;
      href_d1_q        <= 1'b0;
      href_d2_q        <= 1'b0;
      data_d1_q        <= 8'd0;
      frame_cnt_q      <= 8'd0;
      out_en_q         <= 1'b0;
      byte_flag_q      <= 1'b0;
      hi_byte_q        <= 8'd0;
      word_q           <= 16'd0;
      pix_stb_q        <= 1'b0;
      cmos_pclk_ce     <= 1'b0;
      cmos_frame_vsync <= 1'b0;
      cmos_frame_herf  <= 1'b0;
      cmos_frame_valid <= 1'b0;
      cmos_frame_data  <= 24'd0;
    end else begin
      vsync_d1_q       <= cmos_vsync;
      vsync_d2_q       <= vsync_d1_q;
      href_d1_q        <= cmos_herf;
      href_d2_q        <= href_d1_q;
      data_d1_q        <= cmos_data;
      frame_cnt_q      <= frame_cnt_d;
      out_en_q         <= out_en_d;
      byte_flag_q      <= byte_flag_d;
      hi_byte_q        <= hi_byte_d;
      word_q           <= word_d;
      pix_stb_q        <= pix_stb_d;
      cmos_pclk_ce     <= pix_stb_q;
      cmos_frame_vsync <= vsync_d2_q & out_en_q;
      cmos_frame_herf  <= href_d2_q & out_en_q;
      cmos_frame_valid <= pix_stb_q & out_en_q;
      if (pix_stb_q && out_en_q) cmos_frame_data <= rgb888;
    end
  end

endmodule

// File: tb/tb_cmos_capture_rgb.sv
// Randomized bench for cmos_capture_rgb with a sample-indexed reference model and literal pixel checks.
module tb_cmos_capture_rgb;

  localparam int FW = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b0;
  logic        hr = 1'b0;
  logic [7:0]  dat = 8'd0;
  logic        cmos_pclk_ce, cmos_frame_vsync, cmos_frame_herf, cmos_frame_valid;
  logic [23:0] cmos_frame_data;

  cmos_capture_rgb #(.FRAME_WAIT(FW)) dut (
    .cmos_pclk(clk), .sys_rst_n(rst_n), .cmos_vsync(vs), .cmos_herf(hr), .cmos_data(dat),
    .cmos_pclk_ce(cmos_pclk_ce), .cmos_frame_vsync(cmos_frame_vsync),
    .cmos_frame_herf(cmos_frame_herf), .cmos_frame_valid(cmos_frame_valid),
    .cmos_frame_data(cmos_frame_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] rgb(input logic [7:0] hi, input logic [7:0] lo);
    int w, r5, g6, b5, r8, g8, b8;
    w  = int'({hi, lo});
    r5 = (w >> 11) & 31;
    g6 = (w >> 5) & 63;
    b5 = w & 31;
    r8 = (r5 << 3) | (r5 >> 2);
    g8 = (g6 << 2) | (g6 >> 4);
    b8 = (b5 << 3) | (b5 >> 2);
    return 24'((r8 << 16) | (g8 << 8) | b8);
  endfunction

  // Reference model: outputs after edge e are a function of input sample e-2.
  int          cyc, rises, runpos;
  logic        prev_vs;
  logic [7:0]  prev_d;
  logic [23:0] hold;
  logic        e_vs[4], e_hr[4], e_ce[4], e_val[4];
  logic [23:0] e_dat[4];

  task automatic model_reset();
    cyc = 0; rises = 0; runpos = 0; prev_vs = 1'b0; prev_d = 8'd0; hold = 24'd0;
    for (int i = 0; i < 4; i++) begin
      e_vs[i] = 1'b0; e_hr[i] = 1'b0; e_ce[i] = 1'b0; e_val[i] = 1'b0; e_dat[i] = 24'd0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        int  e, slot;
        logic en, pix;
        e = cyc + 1;
        slot = (e + 2) % 4;
        if (vs && !prev_vs) rises++;
        en = (rises > FW);
        runpos = hr ? runpos + 1 : 0;
        pix = hr && (runpos % 2 == 0);
        if (pix && en) hold = rgb(prev_d, dat);
        e_vs[slot] = vs & en;
        e_hr[slot] = hr & en;
        e_ce[slot] = pix;
        e_val[slot] = pix & en;
        e_dat[slot] = hold;
        prev_vs = vs;
        prev_d = dat;
        cyc = e;
      end
    end
  end

  int          ce_cnt, val_cnt, hr_cyc, hr_rise, vs_cnt;
  logic        herf_prev = 1'b0;
  logic [23:0] got[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_vsync", 24'(cmos_frame_vsync), 24'd0);
        check("rst_herf",  24'(cmos_frame_herf),  24'd0);
        check("rst_ce",    24'(cmos_pclk_ce),     24'd0);
        check("rst_valid", 24'(cmos_frame_valid), 24'd0);
        check("rst_data",  cmos_frame_data,       24'd0);
      end else begin
        int s;
        s = cyc % 4;
        check("vsync", 24'(cmos_frame_vsync), 24'(e_vs[s]));
        check("herf",  24'(cmos_frame_herf),  24'(e_hr[s]));
        check("ce",    24'(cmos_pclk_ce),     24'(e_ce[s]));
        check("valid", 24'(cmos_frame_valid), 24'(e_val[s]));
        check("data",  cmos_frame_data,       e_dat[s]);
      end
      if (cmos_pclk_ce) ce_cnt++;
      if (cmos_frame_valid) begin
        val_cnt++;
        got.push_back(cmos_frame_data);
      end
      if (cmos_frame_herf) hr_cyc++;
      if (cmos_frame_herf && !herf_prev) hr_rise++;
      if (cmos_frame_vsync) vs_cnt++;
      herf_prev = cmos_frame_herf;
    end
  end

  task automatic drive(input logic v, input logic h, input logic [7:0] d);
    vs = v; hr = h; dat = d;
    @(posedge clk);
    #2;
  endtask

  task automatic clr_counts();
    ce_cnt = 0; val_cnt = 0; hr_cyc = 0; hr_rise = 0; vs_cnt = 0;
    got.delete();
  endtask

  // 4 lines of 32 bytes: 64 pixels per frame.
  task automatic send_frame();
    int n;
    clr_counts();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'd0);
    for (int l = 0; l < 4; l++) begin
      for (int b = 0; b < 32; b++) drive(1'b1, 1'b1, 8'($urandom));
      n = 2 + $urandom_range(0, 3);
      for (int g = 0; g < n; g++) drive(1'b1, 1'b0, 8'($urandom));
    end
    n = 5 + $urandom_range(0, 4);
    for (int g = 0; g < n; g++) drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic check_frame(input string tag, input bit enabled);
    if (enabled) begin
      check({tag, "_valid_cnt"}, 24'(val_cnt), 24'd64);
      check({tag, "_herf_pulses"}, 24'(hr_rise), 24'd4);
      check({tag, "_herf_cycles"}, 24'(hr_cyc), 24'd128);
    end else begin
      check({tag, "_valid_cnt"}, 24'(val_cnt), 24'd0);
      check({tag, "_vsync_cycles"}, 24'(vs_cnt), 24'd0);
      check({tag, "_ce_cnt"}, 24'(ce_cnt), 24'd64);
    end
  endtask

  task automatic send_bytes(input logic [7:0] b[$]);
    foreach (b[i]) drive(1'b1, 1'b1, b[i]);
    for (int g = 0; g < 4; g++) drive(1'b1, 1'b0, 8'd0);
  endtask

  logic [23:0] exp_px[$];

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int f = 1; f <= 6; f++) begin
      send_frame();
      check_frame($sformatf("frame%0d", f), f > FW);
    end

    // Hand-computed pixels, latency and odd-line handling inside an enabled frame.
    clr_counts();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'd0);
    send_bytes('{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'h00, 8'h00,
                 8'hFF, 8'hFF, 8'h84, 8'h10});
    drive(1'b1, 1'b1, 8'h12);
    vs = 1'b1; hr = 1'b1; dat = 8'h34;
    @(posedge clk);
    #2;
    hr = 1'b0; dat = 8'd0;
    @(negedge clk);
    check("lat_valid_N", 24'(cmos_frame_valid), 24'd0);
    check("lat_herf_N", 24'(cmos_frame_herf), 24'd0);
    @(negedge clk);
    check("lat_valid_N1", 24'(cmos_frame_valid), 24'd0);
    check("lat_herf_N1", 24'(cmos_frame_herf), 24'd1);
    @(negedge clk);
    check("lat_valid_N2", 24'(cmos_frame_valid), 24'd1);
    check("lat_data_N2", cmos_frame_data, 24'h1045A5);
    @(negedge clk);
    check("lat_valid_N3", 24'(cmos_frame_valid), 24'd0);
    @(posedge clk);
    #2;
    send_bytes('{8'hF8, 8'h00, 8'h07, 8'hE0, 8'hAA});
    send_bytes('{8'h00, 8'h1F});
    for (int g = 0; g < 5; g++) drive(1'b0, 1'b0, 8'd0);
    exp_px = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h000000, 24'hFFFFFF, 24'h848284,
               24'h1045A5, 24'hFF0000, 24'h00FF00, 24'h0000FF};
    check("pix_count", 24'(got.size()), 24'(exp_px.size()));
    foreach (exp_px[i])
      check($sformatf("pix%0d", i), (i < got.size()) ? got[i] : 24'hXXXXXX, exp_px[i]);

    // Asynchronous reset mid-line inside an output frame.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'd0);
    for (int b = 0; b < 10; b++) drive(1'b1, 1'b1, 8'($urandom));
    #1;
    rst_n = 1'b0;
    #1;
    check("async_vsync", 24'(cmos_frame_vsync), 24'd0);
    check("async_herf",  24'(cmos_frame_herf),  24'd0);
    check("async_ce",    24'(cmos_pclk_ce),     24'd0);
    check("async_valid", 24'(cmos_frame_valid), 24'd0);
    check("async_data",  cmos_frame_data,       24'd0);
    vs = 1'b0; hr = 1'b0; dat = 8'd0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int f = 1; f <= FW + 1; f++) begin
      send_frame();
      check_frame($sformatf("post_rst_frame%0d", f), f > FW);
    end

    // Unstructured traffic: glitchy vsync, href outside frames, odd runs.
    for (int c = 0; c < 1500; c++) begin
      logic v, h;
      v = vs; h = hr;
      if ($urandom_range(0, 39) == 0) v = ~v;
      if ($urandom_range(0, 5) == 0) h = ~h;
      drive(v, h, 8'($urandom));
    end
    for (int g = 0; g < 5; g++) drive(1'b0, 1'b0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
